// File: rtl/dcs_pkg.sv
// Shared defaults and state encoding for the DCSformer host controller.
package dcs_pkg;

  localparam int unsigned DCS_N_IN    = 128;
  localparam int unsigned DCS_N_W     = 8;
  localparam int unsigned DCS_N_OUT   = 8;
  localparam int unsigned DCS_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    SEND_I,
    WAIT_WR,
    SEND_W,
    RECV,
    DONE,
    ERR
  } dcs_host_state_t;

endpackage

// File: rtl/dcs_timeout_cnt.sv
// Clearable, saturating idle-cycle counter; tc flags TIMEOUT-1 idle cycles reached.
module dcs_timeout_cnt
  import dcs_pkg::*;
#(
  parameter int unsigned TIMEOUT = DCS_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT - 1));

  // Count idle cycles, holding at the terminal value until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dcs_host_ctrl.sv
// Host-side initiator: buffers a job, streams it to the accelerator, captures results.
module dcs_host_ctrl
  import dcs_pkg::*;
#(
  parameter int unsigned N_IN    = DCS_N_IN,
  parameter int unsigned N_W     = DCS_N_W,
  parameter int unsigned N_OUT   = DCS_N_OUT,
  parameter int unsigned TIMEOUT = DCS_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_en,
  input  logic [7:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        start,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        i_valid,
  output logic [7:0]  i_data,
  input  logic        w_ready,
  output logic        w_valid,
  output logic [7:0]  w_data,
  input  logic        o_valid,
  input  logic [31:0] o_data
);

  localparam int unsigned IW = $clog2(N_IN);
  localparam int unsigned WW = $clog2(N_W);
  localparam int unsigned OW = $clog2(N_OUT);

  dcs_host_state_t state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [OW-1:0]   cnt;
  logic [WW-1:0]   w_sel;

  logic [7:0]  in_buf [N_IN];
  logic [7:0]  w_buf  [N_W];
  logic [31:0] res    [N_OUT];

  logic       in_wait, tmo_clr, tmo_tc;
  logic       i_valid_d, w_valid_d, busy_d, done_d;
  logic [7:0] i_data_d, w_data_d;

  assign in_wait = (state == WAIT_WR) || (state == RECV);
  assign tmo_clr = !in_wait || ((state == RECV) && o_valid);
  assign w_sel   = WW'(ld_addr - 8'(N_IN));
  assign rd_data = res[rd_addr];

  dcs_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .en    (in_wait),
    .tc    (tmo_tc)
  );

  // State and stream index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state and next-index selection.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEND_I;
          idx_nxt   = '0;
        end
      end
      SEND_I: begin
        if (idx == IW'(N_IN - 1)) begin
          state_nxt = WAIT_WR;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      WAIT_WR: begin
        if (w_ready) begin
          state_nxt = SEND_W;
          idx_nxt   = '0;
        end else if (tmo_tc) begin
          state_nxt = ERR;
        end
      end
      SEND_W: begin
        if (idx == IW'(N_W - 1)) begin
          state_nxt = RECV;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      RECV: begin
        if (o_valid) begin
          if (cnt == OW'(N_OUT - 1)) state_nxt = DONE;
        end else if (tmo_tc) begin
          state_nxt = ERR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    i_valid_d = (state_nxt == SEND_I);
    w_valid_d = (state_nxt == SEND_W);
    busy_d    = (state_nxt != IDLE);
    done_d    = (state_nxt == DONE) || (state_nxt == ERR);
    i_data_d  = '0;
    w_data_d  = '0;
    if (i_valid_d) i_data_d = in_buf[idx_nxt];
    if (w_valid_d) w_data_d = w_buf[idx_nxt[WW-1:0]];
  end

  // Registered outputs and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_valid <= 1'b0;
      i_data  <= '0;
      w_valid <= 1'b0;
      w_data  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      i_valid <= i_valid_d;
      i_data  <= i_data_d;
      w_valid <= w_valid_d;
      w_data  <= w_data_d;
      busy    <= busy_d;
      done    <= done_d;
      if (state_nxt == ERR) err <= 1'b1;
      else if ((state == IDLE) && start) err <= 1'b0;
    end
  end

  // Load port writes (IDLE only) and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_IN; i++) in_buf[i] <= '0;
      for (int unsigned i = 0; i < N_W; i++) w_buf[i] <= '0;
      for (int unsigned i = 0; i < N_OUT; i++) res[i] <= '0;
      cnt <= '0;
    end else begin
      if ((state == IDLE) && ld_en) begin
        if (ld_addr < 8'(N_IN)) in_buf[ld_addr[IW-1:0]] <= ld_data;
        else if (ld_addr < 8'(N_IN + N_W)) w_buf[w_sel] <= ld_data;
      end
      if ((state == IDLE) && start) begin
        cnt <= '0;
      end else if ((state == RECV) && o_valid) begin
        res[cnt] <= o_data;
        cnt      <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcs_host_ctrl.sv
// Self-checking bench for dcs_host_ctrl against a job-level reference model.
module tb_dcs_host_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, ld_en, start, w_ready, o_valid;
  logic [7:0]  ld_addr, ld_data;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data, o_data;
  logic        busy, done, err, i_valid, w_valid;
  logic [7:0]  i_data, w_data;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  logic [7:0]  in_m  [128];
  logic [7:0]  w_m   [8];
  logic [31:0] res_m [8];

  dcs_host_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .err(err), .i_valid(i_valid), .i_data(i_data), .w_ready(w_ready), .w_valid(w_valid),
    .w_data(w_data), .o_valid(o_valid), .o_data(o_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int i = 0; i < 128; i++) in_m[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_m[i] = 8'h00;
      res_m[i] = 32'h0;
    end
  endtask

  task automatic load_byte(input int a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = 8'(a); ld_data = d;
    tick;
    ld_en = 1'b0;
    if (a < 128) in_m[a] = d;
    else if (a < 136) w_m[a-128] = d;
  endtask

  task automatic load_random;
    for (int a = 0; a < 136; a++) load_byte(a, 8'($urandom));
    load_byte(200, 8'($urandom));
  endtask

  task automatic check_results(input string tag);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      total++;
      if (rd_data !== res_m[a]) begin
        bad++; $display("FAIL %s rd_data[%0d]: got %08h want %08h", tag, a, rd_data, res_m[a]);
      end
    end
  endtask

  // Runs one job; wr_gap<0 means w_ready never comes, o_gap<0 means random gaps.
  task automatic run_job(input int wr_gap, input int o_gap, input int n_words,
                         input bit fixed_data, input bit poke, input bit rst_k3);
    int d0;
    int g;
    d0 = done_seen;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_pre: got %0b want 0", busy); end
    start = 1'b1;
    tick;
    start = 1'b0;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %0b want 0", err); end
    for (int j = 0; j < 128; j++) begin
      total++;
      if (i_valid !== 1'b1 || i_data !== in_m[j] || busy !== 1'b1 || w_valid !== 1'b0) begin
        bad++;
        $display("FAIL i_stream[%0d]: got v=%0b d=%02h busy=%0b wv=%0b want v=1 d=%02h busy=1 wv=0",
                 j, i_valid, i_data, busy, w_valid, in_m[j]);
      end
      ld_en = poke && (j == 10); ld_addr = 8'd5; ld_data = 8'hFF;
      start = poke && (j == 20);
      w_ready = poke && (j == 50);
      tick;
    end
    ld_en = 1'b0; start = 1'b0; w_ready = 1'b0;
    if (wr_gap < 0) begin
      for (int c = 0; c < 16; c++) begin
        total++;
        if (i_valid !== 1'b0 || w_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
          bad++;
          $display("FAIL wait_wr[%0d]: got iv=%0b wv=%0b done=%0b err=%0b want all 0",
                   c, i_valid, w_valid, done, err);
        end
        tick;
      end
      total++;
      if (err !== 1'b1 || done !== 1'b1) begin
        bad++; $display("FAIL timeout_end: got err=%0b done=%0b want err=1 done=1", err, done);
      end
      tick;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1 || w_valid !== 1'b0) begin
        bad++;
        $display("FAIL timeout_idle: got done=%0b busy=%0b err=%0b wv=%0b want 0 0 1 0",
                 done, busy, err, w_valid);
      end
      total++;
      if (done_seen - d0 != 1) begin
        bad++; $display("FAIL timeout_done_count: got %0d want 1", done_seen - d0);
      end
      return;
    end
    for (int c = 0; c < wr_gap; c++) begin
      total++;
      if (w_valid !== 1'b0 || i_valid !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL pre_wready[%0d]: got wv=%0b iv=%0b done=%0b want 0", c, w_valid, i_valid, done);
      end
      tick;
    end
    w_ready = 1'b1;
    tick;
    w_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (w_valid !== 1'b1 || w_data !== w_m[k]) begin
        bad++; $display("FAIL w_stream[%0d]: got v=%0b d=%02h want v=1 d=%02h", k, w_valid, w_data, w_m[k]);
      end
      if (rst_k3 && k == 3) begin
        rst_n = 1'b0;
        #1;
        total++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || i_valid !== 1'b0 || done !== 1'b0 || w_data !== 8'h00) begin
          bad++;
          $display("FAIL mid_reset: got wv=%0b busy=%0b iv=%0b done=%0b wd=%02h want all 0",
                   w_valid, busy, i_valid, done, w_data);
        end
        tick;
        tick;
        rst_n = 1'b1;
        clear_model();
        tick;
        total++;
        if (done_seen != d0 || busy !== 1'b0) begin
          bad++; $display("FAIL mid_reset_after: got dones=%0d busy=%0b want 0 0", done_seen - d0, busy);
        end
        return;
      end
      tick;
    end
    total++;
    if (w_valid !== 1'b0 || w_data !== 8'h00) begin
      bad++; $display("FAIL w_stream_end: got v=%0b d=%02h want 0 00", w_valid, w_data);
    end
    for (int n = 0; n < n_words; n++) begin
      g = (n >= 8) ? 0 : (o_gap < 0) ? int'($urandom_range(0, 10)) : o_gap;
      for (int c = 0; c < g; c++) begin
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL recv_gap_done[%0d]: got %0b want 0", n, done); end
        tick;
      end
      o_valid = 1'b1;
      o_data = fixed_data ? 32'h100 + 32'(n) : $urandom;
      if (n < 8) res_m[n] = o_data;
      tick;
      o_valid = 1'b0;
      total++;
      if (n == 7) begin
        if (done !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
          bad++; $display("FAIL done_pulse: got done=%0b busy=%0b err=%0b want 1 1 0", done, busy, err);
        end
      end else if (n > 7) begin
        if (done !== 1'b0 || busy !== 1'b0) begin
          bad++; $display("FAIL extra_word[%0d]: got done=%0b busy=%0b want 0 0", n, done, busy);
        end
      end else if (done !== 1'b0) begin
        bad++; $display("FAIL recv_early_done[%0d]: got %0b want 0", n, done);
      end
    end
    if (n_words <= 8) tick;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL job_end: got done=%0b busy=%0b err=%0b want 0 0 0", done, busy, err);
    end
    check_results("job");
    total++;
    if (done_seen - d0 != 1) begin bad++; $display("FAIL done_count: got %0d want 1", done_seen - d0); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || i_valid !== 1'b0 || w_valid !== 1'b0 ||
        i_data !== 8'h00 || w_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b iv=%0b wv=%0b id=%02h wd=%02h want all 0",
               busy, done, err, i_valid, w_valid, i_data, w_data);
    end
    rst_n = 1'b1;
    tick;
    check_results("reset");
  endtask

  task automatic test_basic;
    for (int i = 0; i < 128; i++) load_byte(i, 8'(i));
    for (int k = 0; k < 8; k++) load_byte(128 + k, 8'(8'h10 + k));
    run_job(0, 0, 8, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_gaps;
    load_random();
    run_job(2, 3, 8, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    load_random();
    run_job(-1, 0, 8, 1'b0, 1'b0, 1'b0);
    tick;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b want 1", err); end
    run_job(1, -1, 8, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_during_busy;
    load_random();
    run_job(3, 1, 8, 1'b0, 1'b1, 1'b0);
    run_job(0, -1, 8, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_job;
    load_random();
    run_job(1, 0, 8, 1'b0, 1'b0, 1'b1);
    check_results("after_reset");
    load_random();
    run_job(4, -1, 8, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_extra_words;
    load_random();
    run_job(0, 0, 10, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) begin
      load_random();
      run_job(int'($urandom_range(0, 12)), -1, 8 + int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; rd_addr = '0;
    w_ready = 1'b0; o_valid = 1'b0; o_data = '0;
    clear_model();
    test_reset();
    test_basic();
    test_gaps();
    test_timeout();
    test_load_during_busy();
    test_reset_mid_job();
    test_extra_words();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
